muldiv_sequencer: RTL
=====================

// Module: muldiv_sequencer
// PURPOSE
//  Iterative multiply/divide controller that owns the HI/LO pair for MULT, MULTU, DIV and DIVU.
//  Sits in EX beside ALU32Bit and replaces the single-cycle HI_Reg/LO_Reg update path.
//  Runs a shift-add / restoring-divide loop, one bit per cycle.
//  Stalls the pipeline (ORed into the hazard stall) whenever an instruction needs HI/LO before it is final.
// PARAMETERS
//  WIDTH   32  operand width; HI/LO are WIDTH bits each
//  CNT_W   6   iteration counter width; must hold WIDTH
// PORTS
//  Clk        in   1      clock; all state updates on the rising edge
//  Rst        in   1      synchronous, active-high reset
//  Start      in   1      EX holds a mult/div; sampled only in IDLE
//  Op         in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  OperandA   in   WIDTH  rs (multiplicand / dividend)
//  OperandB   in   WIDTH  rt (multiplier / divisor)
//  Cancel     in   1      pipeline flush; aborts the operation in flight
//  HiLoRead   in   1      ID holds mfhi/mflo
//  MtWrite    in   2      [1] mthi, [0] mtlo
//  MtData     in   WIDTH  data for mthi/mtlo
//  HiOut      out  WIDTH  HI register
//  LoOut      out  WIDTH  LO register
//  Busy       out  1      state != IDLE
//  Done       out  1      one-cycle pulse when HI/LO take a new result
//  DivByZero  out  1      pulses with Done when a DIV/DIVU had divisor 0
//  Stall      out  1      Busy & (HiLoRead | Start | |MtWrite)
// BEHAVIOUR
//  Reset: state IDLE; HiOut, LoOut, counter and all work registers are 0; Busy, Done, DivByZero, Stall are 0.
//  FSM IDLE -> CALC -> FIXUP -> IDLE.
//  IDLE:
//   - Start & ~Cancel: latch operand magnitudes (abs value for signed Op) and the result sign bits.
//   - Load counter = WIDTH, go to CALC.
//   - Else, if MtWrite is set, write MtData to the selected HI/LO in that cycle.
//  CALC:
//   - One iteration per cycle; counter decrements.
//   - At counter==1 the next state is FIXUP.
//  FIXUP:
//   - Apply the sign correction.
//   - Write HI/LO, pulse Done, go to IDLE.
//  Latency: Start in cycle 0 gives Done and new HI/LO in cycle WIDTH+1 (33 by default).
//   - A new Start is accepted in cycle WIDTH+2.
//  Multiply: {HI,LO} = 2*WIDTH-bit product; signed result when Op=MULT.
//  Divide: LO = quotient, truncated toward zero. HI = remainder, which takes the dividend's sign.
//  Divide by zero: LO = all ones, HI = OperandA; DivByZero=1 with Done. Still takes the full latency.
//  Signed overflow: -2^31 / -1 gives LO=0x80000000, HI=0. No flag.
//  HI/LO hold their old values until FIXUP and are never partially updated.
//  Cancel in CALC or FIXUP: go to IDLE next cycle; HI/LO unchanged; no Done pulse.
//  Cancel with Start in IDLE: Cancel wins and the op is not started.
//  Start or MtWrite while Busy: Stall asserts; input ignored; EX keeps re-presenting it until Busy=0.
//  HiLoRead in FIXUP stalls. The read after the stall sees the new HI/LO.
//  Rst asserted mid-operation: full reset next edge; any partial result is discarded.
// CONFIGURATION
//  MULDIV_EARLY_OUT_EN defined:
//   - In CALC a multiply goes to FIXUP as soon as the remaining multiplier bits are all zero.
//   - Minimum latency is 2 cycles (operand B = 0 or 1).
//   - Divide latency is unchanged.
//  MULDIV_EARLY_OUT_EN undefined:
//   - Every operation takes exactly WIDTH+1 cycles from Start to Done.
//   - The early-out logic is not built.
// TESTING
//  1. MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> Done at cycle 33; HI=0xFFFFFFFE, LO=0x00000001.
//  2. MULT A=-7 B=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV A=-7 B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//  3. DIVU A=100 B=0 -> LO=0xFFFFFFFF, HI=100, DivByZero=1 for one cycle with Done.
//  4. Start MULT; HiLoRead=1 in cycles 1..33 -> Stall=1 through cycle 33; HI/LO old until cycle 33, new at 34.
//  5. Start DIV A=50 B=5; Cancel at cycle 10 -> Busy=0 at cycle 11; HI/LO keep prior values; no Done.
//  6. mthi 0x1234 in IDLE -> HiOut=0x1234 next cycle. Same during Busy -> Stall=1, HI unchanged.
//     Early-out build: MULTU B=1 -> Done at cycle 2.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative HI/LO multiply/divide sequencer: one shift-add or restoring-divide bit per cycle.
// Optional MULDIV_EARLY_OUT_EN: multiplies finish as soon as the remaining multiplier bits are zero.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             Clk_i,
  input  logic             Rst_i,
  input  logic             Start_i,
  input  logic [1:0]       Op_i,
  input  logic [WIDTH-1:0] OperandA_i,
  input  logic [WIDTH-1:0] OperandB_i,
  input  logic             Cancel_i,
  input  logic             HiLoRead_i,
  input  logic [1:0]       MtWrite_i,
  input  logic [WIDTH-1:0] MtData_i,
  output logic [WIDTH-1:0] HiOut_o,
  output logic [WIDTH-1:0] LoOut_o,
  output logic             Busy_o,
  output logic             Done_o,
  output logic             DivByZero_o,
  output logic             Stall_o
);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]     shf_q, shf_d;   // multiplier, or dividend shifting out / quotient shifting in
  logic [2*WIDTH-1:0]   add_q, add_d;   // multiplicand (shifted left), or divisor in the low half
  logic [2*WIDTH-1:0]   acc_q, acc_d;   // product, or partial remainder in the low half
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, dbz_q, dbz_d;

  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       trial;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  assign a_neg = ~Op_i[0] & OperandA_i[WIDTH-1];
  assign b_neg = ~Op_i[0] & OperandB_i[WIDTH-1];
  assign mag_a = a_neg ? -OperandA_i : OperandA_i;
  assign mag_b = b_neg ? -OperandB_i : OperandB_i;

  // Borrow out of the trial subtraction means the divisor did not fit this step.
  assign trial    = {acc_q[WIDTH-1:0], shf_q[WIDTH-1]} - {1'b0, add_q[WIDTH-1:0]};
  assign prod_fix = neg_q  ? -acc_q : acc_q;
  assign quo_fix  = neg_q  ? -shf_q : shf_q;
  assign rem_fix  = rneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    shf_d   = shf_q;
    add_d   = add_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dbz_d   = dbz_q;
    Done_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start_i && !Cancel_i) begin
          state_d = CALC;
          cnt_d   = CNT_W'(WIDTH);
          div_d   = Op_i[1];
          neg_d   = a_neg ^ b_neg;
          rneg_d  = a_neg;
          dbz_d   = Op_i[1] && (OperandB_i == '0);
          shf_d   = Op_i[1] ? mag_a : mag_b;
          add_d   = {{WIDTH{1'b0}}, (Op_i[1] ? mag_b : mag_a)};
          acc_d   = '0;
        end else begin
          if (MtWrite_i[1]) hi_d = MtData_i;
          if (MtWrite_i[0]) lo_d = MtData_i;
        end
      end
      CALC: begin
        if (Cancel_i) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (div_q) begin
            if (!trial[WIDTH]) begin
              acc_d = {{WIDTH{1'b0}}, trial[WIDTH-1:0]};
              shf_d = {shf_q[WIDTH-2:0], 1'b1};
            end else begin
              acc_d = {{WIDTH{1'b0}}, acc_q[WIDTH-2:0], shf_q[WIDTH-1]};
              shf_d = {shf_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            if (shf_q[0]) acc_d = acc_q + add_q;
            add_d = add_q << 1;
            shf_d = shf_q >> 1;
          end
          if (cnt_q == CNT_W'(1)) state_d = FIXUP;
`ifdef MULDIV_EARLY_OUT_EN
          if (!div_q && shf_q[WIDTH-1:1] == '0) state_d = FIXUP;
`else
`endif
        end
      end
      FIXUP: begin
        state_d = IDLE;
        if (!Cancel_i) begin
          Done_o = 1'b1;
          if (div_q) begin
            hi_d = rem_fix;
            lo_d = dbz_q ? '1 : quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      shf_q   <= '0;
      add_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      shf_q   <= shf_d;
      add_q   <= add_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dbz_q   <= dbz_d;
    end
  end

  assign HiOut_o     = hi_q;
  assign LoOut_o     = lo_q;
  assign Busy_o      = (state_q != IDLE);
  assign DivByZero_o = Done_o & dbz_q;
  assign Stall_o     = Busy_o & (HiLoRead_i | Start_i | (|MtWrite_i));

endmodule
